// File: rtl/regfile_32x32.sv
// RV32I integer register file: 31 storage registers (x0 hardwired to zero),
// two combinational read ports and one write port with optional forwarding.

module decoder_5to32 (
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_dec
      assign onehot[gi] = (addr == 5'(gi));
    end
  endgenerate

endmodule

module regfile_32x32 #(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_wren_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o
);

  generate
    if (DATA_W != 32) begin : g_width_check
      $error("regfile_32x32: DATA_W must be 32 for RV32I");
    end
  endgenerate

  logic [31:0]       dec_onehot;
  logic [31:1]       we;
  logic [DATA_W-1:0] regs_q [1:31];
  logic              unused_dec_x0;

  decoder_5to32 u_dec (
    .addr   (rd_addr_i),
    .onehot (dec_onehot)
  );

  // x0 has no storage, so its decode line is deliberately left unconnected.
  assign unused_dec_x0 = dec_onehot[0];

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_we
      assign we[gi] = dec_onehot[gi] & rd_wren_i;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 1; k < 32; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (we[k]) begin
          regs_q[k] <= rd_data_i;
        end
      end
    end
  end

  // Reset forces zero on both ports so a pending bypass cannot leak through.
  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!rst_i && addr != 5'd0) begin
      val = regs_q[addr];
      if (BYPASS_EN && rd_wren_i && rd_addr_i == addr) begin
        val = rd_data_i;
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_addr_i);
  end

  always_comb begin
    rs2_data_o = read_port(rs2_addr_i);
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed self-checking bench; drives a non-bypass and a bypass instance
// from the same stimulus and compares both against hand-computed values.

module tb_regfile_32x32;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_wren;
  logic [31:0] rd_data;
  logic [31:0] rs1_nb, rs2_nb;
  logic [31:0] rs1_bp, rs2_bp;

  int checks = 0;
  int errors = 0;

  regfile_32x32 #(.DATA_W(32), .BYPASS_EN(1'b0)) dut_nb (
    .clk_i      (clk),
    .rst_i      (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rd_addr_i  (rd_addr),
    .rd_wren_i  (rd_wren),
    .rd_data_i  (rd_data),
    .rs1_data_o (rs1_nb),
    .rs2_data_o (rs2_nb)
  );

  regfile_32x32 #(.DATA_W(32), .BYPASS_EN(1'b1)) dut_bp (
    .clk_i      (clk),
    .rst_i      (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rd_addr_i  (rd_addr),
    .rd_wren_i  (rd_wren),
    .rd_data_i  (rd_data),
    .rs1_data_o (rs1_bp),
    .rs2_data_o (rs2_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rd_addr = addr;
    rd_data = data;
    rd_wren = 1'b1;
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    $display("WRITE x%0d <= %08h", addr, data);
  endtask

  task automatic test_reset;
    do_write(5'd1, 32'h0000_0055);
    rs1_addr = 5'd1;
    rs2_addr = 5'd1;
    #1;
    checks++;
    if (rs1_nb !== 32'h55 || rs2_bp !== 32'h55) begin
      errors++;
      $display("FAIL pre_reset_x1 got %08h/%08h need 00000055", rs1_nb, rs2_bp);
    end
    // assert reset between edges and look immediately
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rs1_nb !== 32'h0 || rs2_nb !== 32'h0 || rs1_bp !== 32'h0 || rs2_bp !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got %08h %08h %08h %08h need 0", rs1_nb, rs2_nb, rs1_bp, rs2_bp);
    end
    $display("RESET asserted mid-cycle, outputs %08h %08h", rs1_nb, rs2_nb);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < 32; k++) begin
      rs1_addr = 5'(k);
      rs2_addr = 5'(32 - k);
      #1;
      checks++;
      if (rs1_nb !== 32'h0 || rs2_nb !== 32'h0 || rs1_bp !== 32'h0 || rs2_bp !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_x%0d got %08h %08h need 0", k, rs1_nb, rs2_nb);
      end
    end
    $display("READ x1..x31 after reset checked");
  endtask

  task automatic test_x0;
    @(negedge clk);
    rd_addr  = 5'd0;
    rd_data  = 32'hDEAD_BEEF;
    rd_wren  = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_bp !== 32'h0 || rs2_bp !== 32'h0) begin
      errors++;
      $display("FAIL x0_no_bypass got %08h %08h need 0", rs1_bp, rs2_bp);
    end
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    checks++;
    if (rs1_nb !== 32'h0 || rs2_nb !== 32'h0 || rs1_bp !== 32'h0) begin
      errors++;
      $display("FAIL x0_write got %08h %08h need 0", rs1_nb, rs1_bp);
    end
    $display("WRITE x0 <= deadbeef, READ x0 = %08h", rs1_nb);
  endtask

  task automatic test_sweep;
    logic [31:0] exp1, exp2;
    int nb;
    for (int k = 1; k < 32; k++) begin
      do_write(5'(k), 32'h1000_0000 + 32'(k));
    end
    for (int k = 1; k < 32; k++) begin
      nb = (k % 31) + 1;
      rs1_addr = 5'(k);
      rs2_addr = 5'(nb);
      exp1 = 32'h1000_0000 + 32'(k);
      exp2 = 32'h1000_0000 + 32'(nb);
      #1;
      checks++;
      if (rs1_nb !== exp1 || rs2_nb !== exp2 || rs1_bp !== exp1 || rs2_bp !== exp2) begin
        errors++;
        $display("FAIL sweep_x%0d_x%0d got %08h %08h need %08h %08h",
                 k, nb, rs1_nb, rs2_nb, exp1, exp2);
      end
      $display("READ x%0d=%08h x%0d=%08h", k, rs1_nb, nb, rs2_nb);
    end
  endtask

  task automatic test_enable_gating;
    @(negedge clk);
    rd_addr  = 5'd5;
    rd_data  = 32'hFFFF_FFFF;
    rd_wren  = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rs1_nb !== 32'h1000_0005 || rs2_nb !== 32'h1000_0005 || rs1_bp !== 32'h1000_0005) begin
      errors++;
      $display("FAIL enable_gating got %08h %08h need 10000005", rs1_nb, rs1_bp);
    end
    rd_addr = 5'bxxxxx;
    @(posedge clk);
    #1;
    rd_addr = 5'd0;
    checks++;
    if (rs1_nb !== 32'h1000_0005 || rs1_bp !== 32'h1000_0005) begin
      errors++;
      $display("FAIL x_addr_no_write got %08h %08h need 10000005", rs1_nb, rs1_bp);
    end
    $display("GATED 10 cycles, x5 = %08h", rs1_nb);
  endtask

  task automatic test_same_cycle;
    do_write(5'd7, 32'h0000_0011);
    @(negedge clk);
    rd_addr  = 5'd7;
    rd_data  = 32'h0000_0022;
    rd_wren  = 1'b1;
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_nb !== 32'h11) begin
      errors++;
      $display("FAIL old_value_no_bypass got %08h need 00000011", rs1_nb);
    end
    checks++;
    if (rs1_bp !== 32'h22) begin
      errors++;
      $display("FAIL bypass_rs1 got %08h need 00000022", rs1_bp);
    end
    checks++;
    if (rs2_nb !== 32'h0 || rs2_bp !== 32'h0) begin
      errors++;
      $display("FAIL rs2_x0_during_write got %08h %08h need 0", rs2_nb, rs2_bp);
    end
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    checks++;
    if (rs1_nb !== 32'h22 || rs1_bp !== 32'h22) begin
      errors++;
      $display("FAIL after_edge_x7 got %08h %08h need 00000022", rs1_nb, rs1_bp);
    end
    $display("SAME-CYCLE x7: after edge %08h", rs1_nb);
    // both ports forwarding together
    @(negedge clk);
    rd_addr  = 5'd9;
    rd_data  = 32'h0000_0033;
    rd_wren  = 1'b1;
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    #1;
    checks++;
    if (rs1_bp !== 32'h33 || rs2_bp !== 32'h33 || rs1_nb !== 32'h1000_0009 || rs2_nb !== 32'h1000_0009) begin
      errors++;
      $display("FAIL dual_bypass_x9 got %08h %08h %08h %08h need 33 33 10000009 10000009",
               rs1_bp, rs2_bp, rs1_nb, rs2_nb);
    end
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    $display("DUAL-BYPASS x9 = %08h", rs1_bp);
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    rd_addr  = 5'd3;
    rd_data  = 32'h0000_00AA;
    rd_wren  = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rs1_bp !== 32'h0 || rs2_bp !== 32'h0 || rs1_nb !== 32'h0) begin
      errors++;
      $display("FAIL bypass_in_reset got %08h %08h need 0", rs1_bp, rs1_nb);
    end
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    rd_data = 32'h0000_00BB;
    #1;
    checks++;
    if (rs1_nb !== 32'h0) begin
      errors++;
      $display("FAIL x3_after_reset got %08h need 0", rs1_nb);
    end
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    checks++;
    if (rs1_nb !== 32'hBB || rs2_bp !== 32'hBB) begin
      errors++;
      $display("FAIL first_write_after_reset got %08h %08h need 000000bb", rs1_nb, rs2_bp);
    end
    rs1_addr = 5'd7;
    #1;
    checks++;
    if (rs1_nb !== 32'h0 || rs1_bp !== 32'h0) begin
      errors++;
      $display("FAIL x7_cleared got %08h %08h need 0", rs1_nb, rs1_bp);
    end
    $display("RESET mid-write: x3 = %08h after first write", rs2_nb);
  endtask

  initial begin
    rst      = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    rd_addr  = 5'd0;
    rd_wren  = 1'b0;
    rd_data  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_x0;
    test_sweep;
    test_enable_gating;
    test_same_cycle;
    test_reset_mid_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
